// File: rtl/r2rv_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate extractors and the reservation-station entry.
// Pure types and functions, so there is no latency and no backpressure.
package r2rv_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef struct packed {
      logic [9:0]  op;
      logic [4:0]  qj;
      logic [4:0]  qk;
      logic [4:0]  dest;
      logic [31:0] vj;
      logic [31:0] vk;
      logic [31:0] a;
      logic        a_rdy;
      logic [2:0]  rwmm;
      logic        is_branch;
      logic        is_load;
      logic        is_store;
      logic        illegal;
   } decoded_t;

   function automatic logic [31:0] imm_i(input logic [31:0] i);
      return {{20{i[31]}}, i[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] i);
      return {{20{i[31]}}, i[31:25], i[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] i);
      return {i[31:12], 12'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/rv32i_decode_slot.sv
// One decode lane: instruction + PC to reservation-station entry, purely combinational.
// Zero latency; no flow control of its own.
module rv32i_decode_slot
   import r2rv_pkg::*;
(
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   output decoded_t    dec_o
);

   logic [6:0] opc;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       illegal;
   decoded_t   dec;

   assign opc = instr_i[6:0];
   assign rd  = instr_i[11:7];
   assign f3  = instr_i[14:12];
   assign rs1 = instr_i[19:15];
   assign rs2 = instr_i[24:20];
   assign f7  = instr_i[31:25];

   always_comb begin
      dec       = '0;
      dec.a_rdy = 1'b1;
      illegal   = 1'b0;
      case (opc)
         OPC_OP_IMM: begin
            dec.op   = {f3, 7'b0};
            dec.qj   = rs1;
            dec.vk   = imm_i(instr_i);
            dec.dest = rd;
         end
         OPC_LUI: begin
            dec.vk   = imm_u(instr_i);
            dec.dest = rd;
         end
         OPC_AUIPC: begin
            dec.vj   = pc_i;
            dec.vk   = imm_u(instr_i);
            dec.dest = rd;
         end
         OPC_OP: begin
            dec.op   = {f3, f7};
            dec.qj   = rs1;
            dec.qk   = rs2;
            dec.dest = rd;
            illegal  = (f7 != 7'h00) && (f7 != 7'h20);
         end
         OPC_JAL: begin
            dec.a         = pc_i + imm_j(instr_i);
            dec.dest      = rd;
            dec.is_branch = 1'b1;
         end
         OPC_JALR: begin
            dec.qj        = rs1;
            dec.a         = imm_i(instr_i);
            dec.a_rdy     = 1'b0;
            dec.dest      = rd;
            dec.is_branch = 1'b1;
         end
         OPC_BRANCH: begin
            dec.qj        = rs1;
            dec.qk        = rs2;
            dec.a         = pc_i + imm_b(instr_i);
            dec.is_branch = 1'b1;
            illegal       = (f3 == 3'd2) || (f3 == 3'd3);
         end
         OPC_LOAD: begin
            dec.qj      = rs1;
            dec.a       = imm_i(instr_i);
            dec.a_rdy   = 1'b0;
            dec.dest    = rd;
            dec.rwmm    = f3;
            dec.is_load = 1'b1;
            illegal     = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         end
         OPC_STORE: begin
            dec.qj       = rs1;
            dec.qk       = rs2;
            dec.a        = imm_s(instr_i);
            dec.a_rdy    = 1'b0;
            dec.rwmm     = f3;
            dec.is_store = 1'b1;
            illegal      = (f3 > 3'd2);
         end
         OPC_MISC_MEM, OPC_SYSTEM: begin
         end
         default: illegal = 1'b1;
      endcase
      // Illegal entries still reach the ROB, but as an inert no-op carrying the trap flag.
      if (illegal) begin
         dec         = '0;
         dec.a_rdy   = 1'b1;
         dec.illegal = 1'b1;
      end
   end

   assign dec_o = dec;

endmodule

// File: rtl/decode_queue.sv
// Circular fetch buffer presenting up to W decoded entries per cycle; push visible the cycle after.
// in_ready depends only on registered occupancy; flush empties the queue next cycle.
module decode_queue
   import r2rv_pkg::*;
#(
   parameter  int W     = 2,
   parameter  int DEPTH = 8,
   localparam int IW    = $clog2(W + 1),
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic [IW-1:0]        in_count,
   input  logic [W-1:0][31:0]   in_instr,
   input  logic [W-1:0][31:0]   in_pc,
   output logic                 in_ready,
   output logic [W-1:0]         out_valid,
   output decoded_t [W-1:0]     out_dec,
   output logic [W-1:0][31:0]   out_pc,
   input  logic [IW-1:0]        out_accept
);

   logic [31:0]   instr_q [DEPTH];
   logic [31:0]   pc_q    [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] avail;
   logic          push;

   assign in_ready = (CW'(DEPTH) - count_q) >= CW'(W);
   assign push     = in_ready && (in_count != '0);
   assign avail    = (count_q < CW'(W)) ? count_q : CW'(W);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(out_accept);
         count_d = count_q - CW'(out_accept);
         if (push) begin
            tail_d  = tail_q + PW'(in_count);
            count_d = count_d + CW'(in_count);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (!reset && !flush && push) begin
         for (int j = 0; j < W; j++) begin
            if (IW'(j) < in_count) begin
               instr_q[tail_q + PW'(j)] <= in_instr[j];
               pc_q[tail_q + PW'(j)]    <= in_pc[j];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!((in_count != '0) && !in_ready));
         assert (CW'(out_accept) <= avail);
      end
   end

   for (genvar i = 0; i < W; i++) begin : g_lane
      logic [PW-1:0] idx;
      assign idx          = head_q + PW'(i);
      assign out_valid[i] = count_q > CW'(i);
      assign out_pc[i]    = pc_q[idx];

      rv32i_decode_slot u_slot (
         .instr_i (instr_q[idx]),
         .pc_i    (pc_q[idx]),
         .dec_o   (out_dec[i])
      );
   end

endmodule
